sar_seq_ctrl: RTL and testbench

SAR_SEQ_CTRL -- requirements
Module: sar_seq_ctrl

---
 rtl/sar_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_sar_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_seq_ctrl.sv
// Successive-approximation ADC sequencer: scans enabled channels, runs sample/convert, holds result until ack.
// Optional SAR_AVG_EN: four conversions per channel, averaged result.
module sar_seq_ctrl #(
    parameter int N          = 8,
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int SAMPLE_CYC = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic [NCH-1:0] ch_en,
    input  logic           cmp,
    input  logic           ack,
    output logic [CHW-1:0] ch_sel,
    output logic           sample,
    output logic [N-1:0]   value,
    output logic [N-1:0]   result,
    output logic [CHW-1:0] result_ch,
    output logic           valid
);
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    localparam int CNTW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt;
    logic [N-1:0]    ring;
    logic            any_en, last_sample, conv_last;
    logic [CHW-1:0]  ch_low, ch_next, ch_above;
    logic            above_found;

    assign any_en      = |ch_en;
    assign last_sample = (cnt == CNTW'(SAMPLE_CYC - 1));

`ifdef SAR_AVG_EN
    logic [1:0]   avg_cnt;
    logic [N-1:0] code;
    logic [N+1:0] acc, sum;
    assign code      = cmp ? (result | ring) : result;
    assign sum       = acc + {2'b00, code};
    assign conv_last = (avg_cnt == 2'd3);
`else
    assign conv_last = 1'b1;
`endif

    // Descending scan: the last hit is the lowest enabled channel (above ch_sel for ch_above).
    always_comb begin
        ch_low      = '0;
        ch_above    = '0;
        above_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                ch_low = CHW'(i);
                if (i > int'(ch_sel)) begin
                    ch_above    = CHW'(i);
                    above_found = 1'b1;
                end
            end
        end
        ch_next = above_found ? ch_above : ch_low;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go && any_en) state_nx = SAMPLE;
            SAMPLE:  if (!go) state_nx = IDLE;
                     else if (last_sample) state_nx = CONVERT;
            CONVERT: if (!go) state_nx = IDLE;
                     else if (ring[0]) state_nx = conv_last ? DONE : SAMPLE;
            DONE:    if (ack) state_nx = (go && any_en) ? SAMPLE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sample = (state == SAMPLE);
        valid  = (state == DONE);
        value  = result | ring;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_sel    <= '0;
            result_ch <= '0;
            result    <= '0;
            ring      <= '0;
            cnt       <= '0;
`ifdef SAR_AVG_EN
            acc       <= '0;
            avg_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ring   <= '0;
                    result <= '0;
                    cnt    <= '0;
`ifdef SAR_AVG_EN
                    acc     <= '0;
                    avg_cnt <= '0;
`endif
                    if (state_nx == SAMPLE) ch_sel <= ch_low;
                end
                SAMPLE: begin
                    if (state_nx == IDLE) begin
                        ring   <= '0;
                        result <= '0;
                        cnt    <= '0;
                    end else if (state_nx == CONVERT) begin
                        cnt    <= '0;
                        ring   <= MSB;
                        result <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (!go) begin
                        ring   <= '0;
                        result <= '0;
                    end else begin
                        ring <= ring >> 1;
                        if (cmp) result <= result | ring;
                        if (ring[0]) result_ch <= ch_sel;
`ifdef SAR_AVG_EN
                        // Last bit resolved: fold this code into the running sum.
                        if (ring[0]) begin
                            if (conv_last) begin
                                result  <= sum[N+1:2];
                                acc     <= '0;
                                avg_cnt <= '0;
                            end else begin
                                result  <= '0;
                                acc     <= sum;
                                avg_cnt <= avg_cnt + 2'd1;
                            end
                        end
`endif
                    end
                end
                DONE: begin
                    if (ack) begin
                        result <= '0;
                        if (state_nx == SAMPLE) ch_sel <= ch_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Bench for sar_seq_ctrl (default build): ideal comparator against a tb analog level, channel-scan model.
module tb_sar_seq_ctrl;
    localparam int N   = 8;
    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int SC  = 8;

    logic           clk, rst_n, go, cmp, ack;
    logic [NCH-1:0] ch_en;
    logic [CHW-1:0] ch_sel, result_ch;
    logic           sample, valid;
    logic [N-1:0]   value, result;
    logic [N-1:0]   analog;

    int n_tests = 0;
    int n_fail  = 0;

    sar_seq_ctrl #(.N(N), .NCH(NCH), .CHW(CHW), .SAMPLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .ch_en(ch_en), .cmp(cmp), .ack(ack),
        .ch_sel(ch_sel), .sample(sample), .value(value), .result(result),
        .result_ch(result_ch), .valid(valid)
    );

    assign cmp = (analog >= value);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DAC code during the k-th convert cycle: resolved upper bits of the input plus the trial bit.
    function automatic logic [N-1:0] exp_val(input logic [N-1:0] a, input int k);
        int hi;
        hi = (int'(a) >> (N - k)) << (N - k);
        return N'(hi | (1 << (N - 1 - k)));
    endfunction

    function automatic int next_ch(input int cur, input logic [NCH-1:0] en);
        for (int d = 1; d <= NCH; d++) begin
            if (en[(cur + d) % NCH]) return (cur + d) % NCH;
        end
        return 0;
    endfunction

    task automatic wait_valid(input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!valid && t < 200);
        n_tests++;
        if (!valid) begin
            n_fail++;
            $display("FAIL %s: valid timeout got %0b expected 1", tag, valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; go = 1'b0; ack = 1'b0; ch_en = '0; analog = '0;
        #3;
        n_tests++;
        if ({sample, valid, value, result, result_ch, ch_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {sample, valid, value, result, result_ch, ch_sel});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (sample !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_go: got sample=%0b valid=%0b expected 0 0", sample, valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        ch_en = 4'b0001; analog = 8'hA5; go = 1'b1; ack = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= SC + N + 1; c++) begin
            @(negedge clk);
            n_tests++;
            if (c <= SC) begin
                if (sample !== 1'b1 || valid !== 1'b0 || ch_sel !== 2'd0) begin
                    n_fail++;
                    $display("FAIL single_sample c%0d: got s=%0b v=%0b ch=%0d expected 1 0 0",
                             c, sample, valid, ch_sel);
                end
            end else if (c <= SC + N) begin
                if (sample !== 1'b0 || valid !== 1'b0 || value !== exp_val(analog, c - SC - 1)) begin
                    n_fail++;
                    $display("FAIL single_value c%0d: got s=%0b v=%0b value=%0h expected 0 0 %0h",
                             c, sample, valid, value, exp_val(analog, c - SC - 1));
                end
            end else begin
                if (valid !== 1'b1 || result !== 8'hA5 || result_ch !== 2'd0 || value !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL single_done: got v=%0b res=%0h ch=%0d value=%0h expected 1 a5 0 a5",
                             valid, result, result_ch, value);
                end
            end
        end
        ack = 1'b1; go = 1'b0;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || value !== '0 || sample !== 1'b0) begin
            n_fail++;
            $display("FAIL single_to_idle: got v=%0b value=%0h s=%0b expected 0 0 0", valid, value, sample);
        end
    endtask

    task automatic test_back_to_back(input logic [NCH-1:0] mask);
        int exp_ch, hold;
        @(negedge clk);
        ch_en = mask; go = 1'b1; ack = 1'b0; analog = N'($urandom);
        exp_ch = next_ch(NCH - 1, mask);
        for (int k = 0; k < 6; k++) begin
            wait_valid("b2b_wait");
            n_tests++;
            if (result !== analog || result_ch !== CHW'(exp_ch)) begin
                n_fail++;
                $display("FAIL b2b_result k%0d: got res=%0h ch=%0d expected %0h %0d",
                         k, result, result_ch, analog, exp_ch);
            end
            hold = $urandom_range(1, 5);
            repeat (hold) begin
                @(negedge clk);
                n_tests++;
                if (valid !== 1'b1 || result !== analog || result_ch !== CHW'(exp_ch) || sample !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_hold k%0d: got v=%0b res=%0h ch=%0d s=%0b expected 1 %0h %0d 0",
                             k, valid, result, result_ch, sample, analog, exp_ch);
                end
            end
            ack = 1'b1;
            if (k == 5) go = 1'b0;
            @(posedge clk);
            #1 ack = 1'b0;
            analog = N'($urandom);
            exp_ch = next_ch(exp_ch, mask);
        end
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0 || sample !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%0b s=%0b expected 0 0", valid, sample);
        end
    endtask

    task automatic test_rotation();
        int exp_seq[4] = '{1, 3, 1, 3};
        bit bad_sel;
        bad_sel = 1'b0;
        @(negedge clk);
        ch_en = 4'b1010; analog = 8'h3C; ack = 1'b1; go = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
                if (sample && (ch_sel == 2'd0 || ch_sel == 2'd2)) bad_sel = 1'b1;
            end while (!valid && t < 200);
            n_tests++;
            if (valid !== 1'b1 || result_ch !== CHW'(exp_seq[k]) || result !== 8'h3C) begin
                n_fail++;
                $display("FAIL rotation k%0d: got v=%0b ch=%0d res=%0h expected 1 %0d 3c",
                         k, valid, result_ch, result, exp_seq[k]);
            end
        end
        go = 1'b0;
        repeat (20) @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (bad_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL rotation_sel: got disabled channel sampled=%0b expected 0", bad_sel);
        end
    endtask

    task automatic test_abort();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        ch_en = 4'b0100; analog = N'($urandom); go = 1'b1; ack = 1'b0;
        @(posedge clk);
        repeat (SC + 4) @(negedge clk);
        n_tests++;
        if (value !== exp_val(analog, 3) || sample !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pre: got value=%0h s=%0b expected %0h 0", value, sample, exp_val(analog, 3));
        end
        go = 1'b0;
        @(negedge clk);
        n_tests++;
        if (value !== '0 || valid !== 1'b0 || sample !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got value=%0h v=%0b s=%0b expected 0 0 0", value, valid, sample);
        end
        repeat (30) begin
            @(negedge clk);
            if (valid || sample) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got activity=%0b expected 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ch_en = 4'b0110; analog = N'($urandom); go = 1'b1; ack = 1'b0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if (sample !== 1'b1 || ch_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_pre: got s=%0b ch=%0d expected 1 1", sample, ch_sel);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sample, valid, value, result, result_ch, ch_sel} !== '0) begin
            n_fail++;
            $display("FAIL rmid_async: got %0h expected 0", {sample, valid, value, result, result_ch, ch_sel});
        end
        go = 1'b0;
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (sample !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_wait: got s=%0b v=%0b expected 0 0", sample, valid);
        end
        go = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sample !== 1'b1 || ch_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_restart: got s=%0b ch=%0d expected 1 1", sample, ch_sel);
        end
        wait_valid("rmid_wait_valid");
        n_tests++;
        if (result !== analog || result_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_result: got res=%0h ch=%0d expected %0h 1", result, result_ch, analog);
        end
        ack = 1'b1; go = 1'b0;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back(NCH'($urandom_range(1, 15)));
        test_back_to_back(NCH'($urandom_range(1, 15)));
        test_rotation();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
